// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      ARB,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } uart_arb_state_t;

   localparam int unsigned UartArbMaxReq = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: rotated priority encoder starting one past the last winner.
module uart_rr_pick #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [NumReq-1:0] mask,
   input  logic [IdxW-1:0]   last,
   output logic [NumReq-1:0] gnt,
   output logic [IdxW-1:0]   idx,
   output logic              found
);

   logic [NumReq-1:0] cand;
   int unsigned       pos;

   assign cand = req & mask;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned i = 1; i <= NumReq; i++) begin
         pos = (32'(last) + i) % NumReq;
         if (!found && cand[IdxW'(pos)]) begin
            found             = 1'b1;
            gnt[IdxW'(pos)]   = 1'b1;
            idx               = IdxW'(pos);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NumReq byte streams.
// Optional packet lock (req_last) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned DataBits = 8,
   localparam int unsigned IdxW    = $clog2(NumReq)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NumReq*DataBits-1:0] req_data,
   input  logic [NumReq-1:0]          req_valid,
`ifdef UART_ARB_LOCK_EN
   input  logic [NumReq-1:0]          req_last,
`endif
   output logic [NumReq-1:0]          req_ready,
   input  logic                       tx_ready,
   output logic [DataBits-1:0]        tx_data,
   output logic                       tx_valid,
   output logic [IdxW-1:0]            grant_id,
   output logic                       busy
);

   if (NumReq < 2 || NumReq > UartArbMaxReq) begin : gen_num_req_err
      $error("uart_tx_arbiter: NumReq must be in [2,8]");
   end

   uart_arb_state_t     state_q, state_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [IdxW-1:0]     grant_q, grant_d;
   logic [DataBits-1:0] hold_q, hold_d;
   logic [NumReq-1:0]   mask;
   logic [NumReq-1:0]   gnt;
   logic [IdxW-1:0]     win;
   logic                found;

`ifdef UART_ARB_LOCK_EN
   logic lock_q, lock_d;

   // While locked only the packet owner may be granted.
   assign mask = lock_q ? (NumReq'(1) << grant_q) : '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign mask = '1;
`endif

   uart_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req   (req_valid),
      .mask  (mask),
      .last  (last_q),
      .gnt   (gnt),
      .idx   (win),
      .found (found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
         last_q  <= IdxW'(NumReq - 1);
         grant_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      hold_d    = hold_q;
      req_ready = '0;
      tx_valid  = 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_d    = lock_q;
`endif
      unique case (state_q)
         ARB: begin
            if (tx_ready && found) begin
               req_ready = gnt;
               hold_d    = req_data[32'(win)*DataBits +: DataBits];
               grant_d   = win;
               last_d    = win;
               state_d   = ISSUE;
`ifdef UART_ARB_LOCK_EN
               lock_d    = ~req_last[win];
`endif
            end
         end
         ISSUE: begin
            tx_valid = 1'b1;
            state_d  = WAIT_BUSY;
         end
         // uart_tx drops ready one cycle after it samples the byte.
         WAIT_BUSY: begin
            if (!tx_ready) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_ready) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   assign tx_data  = hold_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != ARB);

endmodule
